// File: rtl/ps2_rx_buffered_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

    localparam int PS2_FRAME_BITS   = 11;
    localparam int PS2_PAYLOAD_BITS = 10;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_RECV,
        RX_CHECK
    } ps2_rx_state_t;

    // High when data plus parity bit do not have odd weight.
    function automatic logic odd_parity_err(input logic [8:0] dp);
        return ~^dp;
    endfunction

endpackage

// File: rtl/ps2_rx_buffered_if.sv
// Received-byte stream: head of queue with valid/ready handshake.
interface ps2_rx_buffered_if;
    import ps2_pkg::*;

    logic [7:0] rx_data_o;
    logic       rx_perr_o;
    logic       rx_valid_o;
    logic       rx_ready_i;

    modport master (
        output rx_data_o,
        output rx_perr_o,
        output rx_valid_o,
        input  rx_ready_i
    );

    modport slave (
        input  rx_data_o,
        input  rx_perr_o,
        input  rx_valid_o,
        output rx_ready_i
    );

endinterface

// File: rtl/ps2_rx_fifo.sv
// First-word-fall-through queue; full queue accepts a push when popped.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    // Empty head reads as zero so the output is clean after reset.
    assign rdata_o = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push)
                           - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/ps2_rx_buffered.sv
// PS/2 device-to-host receiver: clock filter, frame FSM, output queue.
module ps2_rx_buffered
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic rx_en_i,
    input  logic ps2c_i,
    input  logic ps2d_i,
    ps2_rx_buffered_if.master rx,
    output logic busy_o,
    output logic frame_err_o,
    output logic timeout_o,
    output logic overflow_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT_CYCLES - 1);

    logic [FILTER_LEN-1:0]       filt_q, filt_d;
    logic                        fclk_q, fclk_d;
    logic                        fall;
    logic [1:0]                  dsync_q;
    logic                        dbit;
    ps2_rx_state_t               state_q, state_d;
    logic [3:0]                  cnt_q, cnt_d;
    logic [TW-1:0]               tmo_q, tmo_d;
    logic [PS2_PAYLOAD_BITS-1:0] sh_q, sh_d;
    logic                        push;
    logic                        pop;
    logic                        full;
    logic                        empty;
    logic [8:0]                  wdata;
    logic [8:0]                  rdata;

    assign filt_d = {filt_q[FILTER_LEN-2:0], ps2c_i};
    assign dbit   = dsync_q[1];

    always_comb begin
        fclk_d = fclk_q;
        if (&filt_q)       fclk_d = 1'b1;
        else if (~|filt_q) fclk_d = 1'b0;
    end

    assign fall = fclk_q & ~fclk_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        sh_d        = sh_q;
        push        = 1'b0;
        frame_err_o = 1'b0;
        timeout_o   = 1'b0;
        overflow_o  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (fall && rx_en_i && !dbit) begin
                    state_d = RX_RECV;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end
            end
            RX_RECV: begin
                if (fall) begin
                    sh_d  = {dbit, sh_q[PS2_PAYLOAD_BITS-1:1]};
                    cnt_d = cnt_q + 4'd1;
                    tmo_d = '0;
                    if (cnt_q == 4'd9) state_d = RX_CHECK;
                end else if (tmo_q == TMO_LIM) begin
                    timeout_o = 1'b1;
                    tmo_d     = '0;
                    state_d   = RX_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            RX_CHECK: begin
                state_d = RX_IDLE;
                if (!sh_q[9]) begin
                    frame_err_o = 1'b1;
                end else begin
                    push       = 1'b1;
                    overflow_o = full & ~pop;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            filt_q  <= '1;
            fclk_q  <= 1'b1;
            dsync_q <= 2'b11;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
            sh_q    <= '0;
        end else begin
            filt_q  <= filt_d;
            fclk_q  <= fclk_d;
            dsync_q <= {dsync_q[0], ps2d_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            sh_q    <= sh_d;
        end
    end

    assign busy_o = (state_q != RX_IDLE);
    assign wdata  = {odd_parity_err(sh_q[8:0]), sh_q[7:0]};
    assign pop    = rx.rx_ready_i & ~empty;

    ps2_rx_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push),
        .wdata_i (wdata),
        .pop_i   (pop),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty)
    );

    assign rx.rx_valid_o = ~empty;
    assign rx.rx_data_o  = rdata[7:0];
    assign rx.rx_perr_o  = rdata[8];

endmodule

// File: tb/tb_ps2_rx_buffered.sv
// Directed and randomized PS/2 frames checked against a byte-queue model.
module tb_ps2_rx_buffered;

    localparam int L     = 4;
    localparam int TMO   = 200;
    localparam int DEPTH = 4;
    localparam int HP    = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_en = 1'b1;
    logic ps2c = 1'b1;
    logic ps2d = 1'b1;
    logic busy, fe, to, ov;

    ps2_rx_buffered_if rif ();

    ps2_rx_buffered #(
        .FILTER_LEN     (L),
        .TIMEOUT_CYCLES (TMO),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk_i       (clk),
        .reset_i     (rst),
        .rx_en_i     (rx_en),
        .ps2c_i      (ps2c),
        .ps2d_i      (ps2d),
        .rx          (rif),
        .busy_o      (busy),
        .frame_err_o (fe),
        .timeout_o   (to),
        .overflow_o  (ov)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int fe_cnt = 0, fe_cyc = 0;
    int to_cnt = 0, ov_cnt = 0;
    int vr_cnt = 0, vr_cyc = 0;
    int br_cnt = 0;
    logic v_prev = 1'b0, b_prev = 1'b0;

    always @(negedge clk) begin
        if (fe === 1'b1) begin
            fe_cnt = fe_cnt + 1;
            fe_cyc = cyc;
        end
        if (to === 1'b1) to_cnt = to_cnt + 1;
        if (ov === 1'b1) ov_cnt = ov_cnt + 1;
        if (rif.rx_valid_o === 1'b1 && !v_prev) begin
            vr_cnt = vr_cnt + 1;
            vr_cyc = cyc;
        end
        if (busy === 1'b1 && !b_prev) br_cnt = br_cnt + 1;
        v_prev = (rif.rx_valid_o === 1'b1);
        b_prev = (busy === 1'b1);
    end

    int n_cmp = 0;
    int n_fail = 0;
    int last_c = 0;
    logic [8:0] mq[$];

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data"}, 32'(rif.rx_data_o), 0);
        chk({tag, "_perr"}, 32'(rif.rx_perr_o), 0);
        chk({tag, "_valid"}, 32'(rif.rx_valid_o), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_ferr"}, 32'(fe), 0);
        chk({tag, "_tmo"}, 32'(to), 0);
        chk({tag, "_ovf"}, 32'(ov), 0);
    endtask

    function automatic logic [8:0] model_entry(
        input logic [7:0] d, input logic par);
        logic perr;
        perr = (($countones(d) + int'(par)) % 2) == 0;
        return {perr, d};
    endfunction

    function automatic logic good_par(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    task automatic send(input logic [7:0] d, input logic par,
                        input logic stp, input int nbits);
        logic [10:0] f;
        f = {stp, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2d = f[i];
            repeat (HP) @(negedge clk);
            ps2c = 1'b0;
            last_c = cyc;
            repeat (HP) @(negedge clk);
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
    endtask

    task automatic pop_check(input string tag);
        logic [8:0] e;
        e = (mq.size() > 0) ? mq.pop_front() : 9'h0;
        chk({tag, "_valid"}, 32'(rif.rx_valid_o), 1);
        chk({tag, "_data"}, 32'(rif.rx_data_o), 32'(e[7:0]));
        chk({tag, "_perr"}, 32'(rif.rx_perr_o), 32'(e[8]));
        rif.rx_ready_i = 1'b1;
        @(negedge clk);
        rif.rx_ready_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        while (mq.size() > 0) pop_check(tag);
        chk({tag, "_empty"}, 32'(rif.rx_valid_o), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe0, v0, t0, o0, ob, b0;
        logic [7:0] d;
        logic par, stp, en;
        rif.rx_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // good 0x1C
        fe0 = fe_cnt;
        v0 = vr_cnt;
        send(8'h1C, 1'b0, 1'b1, 11);
        mq.push_back(model_entry(8'h1C, 1'b0));
        chk("t1_vrise", 32'(vr_cnt - v0), 1);
        chk("t1_vwin", 32'(vr_cyc >= last_c + L + 2 &&
                           vr_cyc <= last_c + L + 3), 1);
        chk("t1_noferr", 32'(fe_cnt - fe0), 0);
        drain("t1");

        // parity error
        send(8'h1C, 1'b1, 1'b1, 11);
        mq.push_back(model_entry(8'h1C, 1'b1));
        drain("t2");

        // stop bit 0
        fe0 = fe_cnt;
        send(8'hF0, 1'b1, 1'b0, 11);
        repeat (4) @(negedge clk);
        chk("t3_ferr", 32'(fe_cnt - fe0), 1);
        chk("t3_fwin", 32'(fe_cyc >= last_c + L + 1 &&
                           fe_cyc <= last_c + L + 2), 1);
        chk("t3_novalid", 32'(rif.rx_valid_o), 0);

        // timeout after 5 bits
        t0 = to_cnt;
        send(8'h35, 1'b0, 1'b1, 5);
        chk("t4_busy", 32'(busy), 1);
        repeat (TMO + 40) @(negedge clk);
        chk("t4_tmo", 32'(to_cnt - t0), 1);
        chk("t4_idle", 32'(busy), 0);
        send(8'hF0, good_par(8'hF0), 1'b1, 11);
        mq.push_back(model_entry(8'hF0, good_par(8'hF0)));
        drain("t4");

        // overflow
        o0 = ov_cnt;
        ob = 0;
        for (int k = 1; k <= 5; k++) begin
            d = 8'(k);
            if (k == 5) ob = ov_cnt;
            send(d, good_par(d), 1'b1, 11);
            if (k <= DEPTH) mq.push_back(model_entry(d, good_par(d)));
        end
        repeat (4) @(negedge clk);
        chk("t5_noov_early", 32'(ob - o0), 0);
        chk("t5_ov", 32'(ov_cnt - ob), 1);
        drain("t5");

        // glitches shorter than the filter
        b0 = br_cnt;
        ps2d = 1'b0;
        for (int g = 0; g < 6; g++) begin
            ps2c = 1'b0;
            repeat (L - 1) @(negedge clk);
            ps2c = 1'b1;
            repeat (L + 2) @(negedge clk);
        end
        ps2d = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_nobusy", 32'(br_cnt - b0), 0);
        chk("t6_idle", 32'(busy), 0);

        // reset mid-frame with a queued byte
        send(8'h3C, good_par(8'h3C), 1'b1, 11);
        send(8'hAA, 1'b0, 1'b1, 4);
        chk("t7_busy", 32'(busy), 1);
        chk("t7_valid", 32'(rif.rx_valid_o), 1);
        rst = 1'b1;
        #1;
        chk_zero("t7_rst");
        mq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send(8'hAA, good_par(8'hAA), 1'b1, 11);
        mq.push_back(model_entry(8'hAA, good_par(8'hAA)));
        drain("t7");

        // randomized frames
        for (int r = 0; r < 24; r++) begin
            d = 8'($urandom);
            par = 1'($urandom);
            stp = ($urandom % 6) != 0;
            en = ($urandom % 5) != 0;
            rx_en = en;
            send(d, par, stp, 11);
            repeat (6) @(negedge clk);
            rx_en = 1'b1;
            if (en && stp) mq.push_back(model_entry(d, par));
            if ($urandom % 3 == 0 || mq.size() == DEPTH)
                drain("rnd");
            repeat ($urandom_range(1, 30)) @(negedge clk);
        end
        drain("rnd_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
